// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-LED duty profile generator and its PWM stage.
//  - DUTY_MAX_DEF : full-scale duty; the PWM stage uses the same value as its frame count max
//  - state_e      : profile FSM state encoding (3-bit)
package breath_pkg;

  localparam int unsigned DUTY_MAX_DEF = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

endpackage

// File: rtl/breath_sat_step.sv
// Combinational saturating step of a duty value, clamped to [0, DUTY_MAX].
// Ports:
//  duty_i       current duty
//  step_i       effective step (already forced non-zero by the caller)
//  up_i         1 = add step, 0 = subtract step
//  next_duty_c_o  stepped and clamped duty (combinational)
module breath_sat_step #(
  parameter int unsigned DUTY_W   = 16,
  parameter int unsigned STEP_W   = 8,
  parameter int unsigned DUTY_MAX = 100
) (
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_i,
  output logic [DUTY_W-1:0] next_duty_c_o
);

  // One extra bit so the sum can never wrap before the clamp.
  localparam int unsigned SUM_W = DUTY_W + 1;

  logic [SUM_W-1:0] duty_ext;
  logic [SUM_W-1:0] step_ext;
  logic [SUM_W-1:0] max_ext;
  logic [SUM_W-1:0] sum;

  assign duty_ext = SUM_W'(duty_i);
  assign step_ext = SUM_W'(step_i);
  assign max_ext  = SUM_W'(DUTY_MAX);

  // Saturating add toward DUTY_MAX or saturating subtract toward 0.
  always_comb begin
    sum           = duty_ext + step_ext;
    next_duty_c_o = duty_i;
    if (up_i) begin
      if (sum >= max_ext) begin
        next_duty_c_o = DUTY_W'(DUTY_MAX);
      end else begin
        next_duty_c_o = sum[DUTY_W-1:0];
      end
    end else begin
      if (duty_ext <= step_ext) begin
        next_duty_c_o = '0;
      end else begin
        next_duty_c_o = duty_i - DUTY_W'(step_i);
      end
    end
  end

endmodule

// File: rtl/breath_profile_gen.sv
// Breathing duty-profile generator: ramps a duty threshold up, holds at full
// scale, ramps down, holds at zero, one step per PWM frame_tick.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  en            run request (level); sampled at start and at end of each cycle
//  frame_tick    1-cycle end-of-frame pulse from the PWM stage
//  cfg_step      duty step per frame (0 behaves as 1)
//  cfg_hold_hi   frames to hold at DUTY_MAX
//  cfg_hold_lo   frames to hold at 0
//  duty          registered duty threshold
//  duty_upd      registered pulse: duty changed on this edge
//  busy          registered: FSM not in IDLE
//  cycle_done    registered pulse: one full breath cycle finished
module breath_profile_gen
  import breath_pkg::*;
#(
  parameter int unsigned DUTY_W   = 16,
  parameter int unsigned DUTY_MAX = DUTY_MAX_DEF,
  parameter int unsigned STEP_W   = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              frame_tick,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold_hi,
  input  logic [HOLD_W-1:0] cfg_hold_lo,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              busy,
  output logic              cycle_done
);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              duty_upd_q, duty_upd_d;
  logic              busy_q, busy_d;
  logic              cycle_done_q, cycle_done_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_hi_q, hold_hi_d;
  logic [HOLD_W-1:0] hold_lo_q, hold_lo_d;

  logic [STEP_W-1:0] eff_step;
  logic [DUTY_W-1:0] sat_duty;
  logic              lo_expire;

  // A zero step would stall the ramp forever, so it is promoted to 1.
  assign eff_step = (step_q == '0) ? STEP_W'(1) : step_q;

  breath_sat_step #(
    .DUTY_W   (DUTY_W),
    .STEP_W   (STEP_W),
    .DUTY_MAX (DUTY_MAX)
  ) u_sat_step (
    .duty_i        (duty_q),
    .step_i        (eff_step),
    .up_i          (state_q == ST_RISE),
    .next_duty_c_o (sat_duty)
  );

  // Next-state, config latch and output-register inputs.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    duty_upd_d   = 1'b0;
    cycle_done_d = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    step_d       = step_q;
    hold_hi_d    = hold_hi_q;
    hold_lo_d    = hold_lo_q;
    lo_expire    = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          step_d    = cfg_step;
          hold_hi_d = cfg_hold_hi;
          hold_lo_d = cfg_hold_lo;
          state_d   = ST_RISE;
        end
      end
      ST_RISE: begin
        if (frame_tick) begin
          duty_d     = sat_duty;
          duty_upd_d = (sat_duty != duty_q);
          if (sat_duty == DUTY_W'(DUTY_MAX)) begin
            if (hold_hi_q == '0) begin
              state_d = ST_FALL;
            end else begin
              state_d    = ST_HOLD_HI;
              hold_cnt_d = hold_hi_q;
            end
          end
        end
      end
      ST_HOLD_HI: begin
        if (frame_tick) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(1)) begin
            state_d = ST_FALL;
          end
        end
      end
      ST_FALL: begin
        if (frame_tick) begin
          duty_d     = sat_duty;
          duty_upd_d = (sat_duty != duty_q);
          if (sat_duty == '0) begin
            if (hold_lo_q == '0) begin
              lo_expire = 1'b1;
            end else begin
              state_d    = ST_HOLD_LO;
              hold_cnt_d = hold_lo_q;
            end
          end
        end
      end
      ST_HOLD_LO: begin
        if (frame_tick) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          if (hold_cnt_q == HOLD_W'(1)) begin
            lo_expire = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // End of a breath: en decides between a fresh cycle and going idle.
    if (lo_expire) begin
      cycle_done_d = 1'b1;
      if (en) begin
        step_d    = cfg_step;
        hold_hi_d = cfg_hold_hi;
        hold_lo_d = cfg_hold_lo;
        state_d   = ST_RISE;
      end else begin
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      duty_q       <= '0;
      duty_upd_q   <= 1'b0;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
      hold_cnt_q   <= '0;
      step_q       <= '0;
      hold_hi_q    <= '0;
      hold_lo_q    <= '0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      duty_upd_q   <= duty_upd_d;
      busy_q       <= busy_d;
      cycle_done_q <= cycle_done_d;
      hold_cnt_q   <= hold_cnt_d;
      step_q       <= step_d;
      hold_hi_q    <= hold_hi_d;
      hold_lo_q    <= hold_lo_d;
    end
  end

  assign duty       = duty_q;
  assign duty_upd   = duty_upd_q;
  assign busy       = busy_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_breath_profile_gen.sv
// Directed self-checking bench for breath_profile_gen (DUTY_MAX = 100).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_breath_profile_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        frame_tick;
  logic [7:0]  cfg_step;
  logic [7:0]  cfg_hold_hi;
  logic [7:0]  cfg_hold_lo;
  logic [15:0] duty;
  logic        duty_upd;
  logic        busy;
  logic        cycle_done;

  int nchk  = 0;
  int nfail = 0;
  int upd_cnt = 0;
  int cd_cnt  = 0;

  always #5 clk = ~clk;

  breath_profile_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .frame_tick  (frame_tick),
    .cfg_step    (cfg_step),
    .cfg_hold_hi (cfg_hold_hi),
    .cfg_hold_lo (cfg_hold_lo),
    .duty        (duty),
    .duty_upd    (duty_upd),
    .busy        (busy),
    .cycle_done  (cycle_done)
  );

  // Pulse counters for whole-cycle totals.
  always @(negedge clk) begin
    if (duty_upd === 1'b1) upd_cnt++;
    if (cycle_done === 1'b1) cd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame_tick cycle, then check the duty presented on the following edge.
  task automatic tick(input int unsigned exp_duty, input logic exp_upd, input string tag);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk({tag, ".duty"}, 32'(duty), 32'(exp_duty));
    chk({tag, ".upd"}, 32'(duty_upd), 32'(exp_upd));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; frame_tick = 1'b0;
    cfg_step = 8'd10; cfg_hold_hi = 8'd0; cfg_hold_lo = 8'd0;

    // Reset held with en=1 and ticks running.
    for (int i = 0; i < 3; i++) begin
      frame_tick = (i != 1);
      @(negedge clk);
      chk("rst.duty", 32'(duty), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.upd", 32'(duty_upd), 32'd0);
      chk("rst.cd", 32'(cycle_done), 32'd0);
    end
    rst = 1'b0; en = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    chk("idle.busy", 32'(busy), 32'd0);

    // Plain ramp, step 10, no holds; en dropped once at full scale.
    cfg_step = 8'd10; en = 1'b1;
    @(negedge clk);
    chk("ramp.busy", 32'(busy), 32'd1);
    upd_cnt = 0; cd_cnt = 0;
    for (int k = 1; k <= 10; k++) tick(10 * k, 1'b1, "ramp.rise");
    en = 1'b0;
    for (int k = 9; k >= 0; k--) tick(10 * k, 1'b1, "ramp.fall");
    chk("ramp.cd", 32'(cycle_done), 32'd1);
    chk("ramp.busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ramp.cd_pulse", 32'(cycle_done), 32'd0);
    chk("ramp.upd_total", 32'(upd_cnt), 32'd20);
    chk("ramp.cd_total", 32'(cd_cnt), 32'd1);

    // Clamping at both ends with step 30.
    cfg_step = 8'd30; en = 1'b1;
    @(negedge clk);
    tick(30, 1'b1, "clamp.r30");
    tick(60, 1'b1, "clamp.r60");
    tick(90, 1'b1, "clamp.r90");
    tick(100, 1'b1, "clamp.r100");
    en = 1'b0;
    tick(70, 1'b1, "clamp.f70");
    tick(40, 1'b1, "clamp.f40");
    tick(10, 1'b1, "clamp.f10");
    tick(0, 1'b1, "clamp.f0");
    chk("clamp.cd", 32'(cycle_done), 32'd1);
    chk("clamp.busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Zero step behaves as step 1.
    cfg_step = 8'd0; en = 1'b1;
    @(negedge clk);
    tick(1, 1'b1, "step0.a");
    tick(2, 1'b1, "step0.b");
    tick(3, 1'b1, "step0.c");
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("step0.rst_duty", 32'(duty), 32'd0);
    chk("step0.rst_busy", 32'(busy), 32'd0);

    // Hold phases: hold_hi=2, hold_lo=3, restart with en still high.
    cfg_step = 8'd50; cfg_hold_hi = 8'd2; cfg_hold_lo = 8'd3; en = 1'b1;
    @(negedge clk);
    tick(50, 1'b1, "hold.r50");
    tick(100, 1'b1, "hold.r100");
    tick(100, 1'b0, "hold.hi1");
    tick(100, 1'b0, "hold.hi2");
    tick(50, 1'b1, "hold.f50");
    tick(0, 1'b1, "hold.f0");
    tick(0, 1'b0, "hold.lo1");
    chk("hold.lo1_cd", 32'(cycle_done), 32'd0);
    tick(0, 1'b0, "hold.lo2");
    chk("hold.lo2_cd", 32'(cycle_done), 32'd0);
    tick(0, 1'b0, "hold.lo3");
    chk("hold.lo3_cd", 32'(cycle_done), 32'd1);
    chk("hold.restart_busy", 32'(busy), 32'd1);
    cfg_step = 8'd10;
    tick(50, 1'b1, "hold.restart50");
    tick(100, 1'b1, "hold.latched_step");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // en drop mid-RISE at duty 40: cycle still completes.
    cfg_step = 8'd10; cfg_hold_hi = 8'd0; cfg_hold_lo = 8'd0; en = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) tick(10 * k, 1'b1, "endrop.rise");
    en = 1'b0;
    for (int k = 5; k <= 10; k++) tick(10 * k, 1'b1, "endrop.cont");
    for (int k = 9; k >= 0; k--) tick(10 * k, 1'b1, "endrop.fall");
    chk("endrop.cd", 32'(cycle_done), 32'd1);
    chk("endrop.busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) tick(0, 1'b0, "endrop.idle_tick");
    chk("endrop.busy_idle", 32'(busy), 32'd0);

    // Reset mid-FALL at duty 60 together with a tick and a cfg change.
    cfg_step = 8'd20; en = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) tick(20 * k, 1'b1, "rstfall.rise");
    tick(80, 1'b1, "rstfall.f80");
    tick(60, 1'b1, "rstfall.f60");
    rst = 1'b1; frame_tick = 1'b1; cfg_step = 8'd30;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0; en = 1'b0;
    chk("rstfall.duty", 32'(duty), 32'd0);
    chk("rstfall.busy", 32'(busy), 32'd0);
    chk("rstfall.upd", 32'(duty_upd), 32'd0);
    chk("rstfall.cd", 32'(cycle_done), 32'd0);
    @(negedge clk);
    chk("rstfall.idle", 32'(busy), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("rstfall.busy_again", 32'(busy), 32'd1);
    tick(30, 1'b1, "rstfall.relatch");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
